mul_share_arbiter: RTL and testbench

//   Shares one constant-time, taint-tracking multiplier between two requesters.

---
 rtl/mul_share_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mul_share_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//   Shares one constant-time, taint-tracking multiplier between two requesters.
//   A round-robin arbiter picks a winner from IDLE. The winner's operands,
//   operand taint and request taint are latched. The multiplier is then driven
//   through reset, start, a fixed wait and capture. The product and its taint
//   go back to the winner.
//   Every operation takes the same number of cycles, whatever the operands,
//   the taint or the winner, so grant-to-done timing leaks nothing.
//
// Ports
//   clk, rst                     clock (rising edge), async active-low reset
//   reqN, reqN_t                 request level (held until gntN) and its taint
//   aN, bN, aN_t, bN_t           operands and bitwise operand taint
//   gntN                         1-cycle grant pulse
//   doneN, doneN_t               1-cycle completion pulse and its taint
//   prodN, prodN_t               product and taint, held until the next doneN
//   mul_rst, mul_start(_t)       multiplier reset / start pulse (+ start taint)
//   mul_multiplier(_t)           latched operand a (+ taint) toward the multiplier
//   mul_multiplicand(_t)         latched operand b (+ taint) toward the multiplier
//   mul_product, mul_product_t   multiplier result and its taint
module mul_share_arbiter #(
  parameter int NUM_BITS    = 7,
  parameter int MUL_LATENCY = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic                    req0_t,
  input  logic [NUM_BITS-1:0]     a0,
  input  logic [NUM_BITS-1:0]     b0,
  input  logic [NUM_BITS-1:0]     a0_t,
  input  logic [NUM_BITS-1:0]     b0_t,
  input  logic                    req1,
  input  logic                    req1_t,
  input  logic [NUM_BITS-1:0]     a1,
  input  logic [NUM_BITS-1:0]     b1,
  input  logic [NUM_BITS-1:0]     a1_t,
  input  logic [NUM_BITS-1:0]     b1_t,
  output logic                    gnt0,
  output logic                    done0,
  output logic                    done0_t,
  output logic [2*NUM_BITS-1:0]   prod0,
  output logic [2*NUM_BITS-1:0]   prod0_t,
  output logic                    gnt1,
  output logic                    done1,
  output logic                    done1_t,
  output logic [2*NUM_BITS-1:0]   prod1,
  output logic [2*NUM_BITS-1:0]   prod1_t,
  output logic                    mul_rst,
  output logic                    mul_start,
  output logic                    mul_start_t,
  output logic [NUM_BITS-1:0]     mul_multiplier,
  output logic [NUM_BITS-1:0]     mul_multiplicand,
  output logic [NUM_BITS-1:0]     mul_multiplier_t,
  output logic [NUM_BITS-1:0]     mul_multiplicand_t,
  input  logic [2*NUM_BITS-1:0]   mul_product,
  input  logic [2*NUM_BITS-1:0]   mul_product_t
);

  localparam int CW = $clog2(MUL_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MRST,
    S_START,
    S_WAIT,
    S_CAP
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic          last_reg;   // owner of the most recently completed operation
  logic          owner_reg;  // requester being served
  logic          req_t_reg;  // latched request taint of the owner
  logic          pick1;      // 1 when requester 1 wins the current arbitration

  // On a tie the requester that was not served last wins; otherwise the
  // single active requester wins.
  assign pick1 = (req0 && req1) ? ~last_reg : req1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg          <= S_IDLE;
      cnt_reg            <= '0;
      last_reg           <= 1'b1;
      owner_reg          <= 1'b0;
      req_t_reg          <= 1'b0;
      gnt0               <= 1'b0;
      gnt1               <= 1'b0;
      done0              <= 1'b0;
      done1              <= 1'b0;
      done0_t            <= 1'b0;
      done1_t            <= 1'b0;
      prod0              <= '0;
      prod0_t            <= '0;
      prod1              <= '0;
      prod1_t            <= '0;
      mul_rst            <= 1'b0;
      mul_start          <= 1'b0;
      mul_start_t        <= 1'b0;
      mul_multiplier     <= '0;
      mul_multiplicand   <= '0;
      mul_multiplier_t   <= '0;
      mul_multiplicand_t <= '0;
    end else begin
      // Pulse outputs default low; each state raises only what it owns.
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      done0_t     <= 1'b0;
      done1_t     <= 1'b0;
      mul_rst     <= 1'b0;
      mul_start   <= 1'b0;
      mul_start_t <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (req0 || req1) begin
            owner_reg          <= pick1;
            gnt0               <= ~pick1;
            gnt1               <= pick1;
            req_t_reg          <= pick1 ? req1_t : req0_t;
            mul_multiplier     <= pick1 ? a1 : a0;
            mul_multiplicand   <= pick1 ? b1 : b0;
            mul_multiplier_t   <= pick1 ? a1_t : a0_t;
            mul_multiplicand_t <= pick1 ? b1_t : b0_t;
            mul_rst            <= 1'b1;
            state_reg          <= S_MRST;
          end
        end

        S_MRST: begin
          mul_start   <= 1'b1;
          mul_start_t <= req_t_reg;
          state_reg   <= S_START;
        end

        S_START: begin
          cnt_reg   <= '0;
          state_reg <= S_WAIT;
        end

        S_WAIT: begin
          // Fixed-length wait; operand values never shorten it.
          if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            state_reg <= S_CAP;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        S_CAP: begin
          // Only the owner's result registers are written.
          if (owner_reg) begin
            prod1   <= mul_product;
            prod1_t <= mul_product_t;
            done1   <= 1'b1;
            done1_t <= req_t_reg;
          end else begin
            prod0   <= mul_product;
            prod0_t <= mul_product_t;
            done0   <= 1'b1;
            done0_t <= req_t_reg;
          end
          last_reg  <= owner_reg;
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;

  localparam int NB = 7;
  localparam int L  = 16;
  localparam int PW = 2 * NB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          req_d  [2];
  logic          req_t_d[2];
  logic [NB-1:0] a_d [2];
  logic [NB-1:0] b_d [2];
  logic [NB-1:0] at_d[2];
  logic [NB-1:0] bt_d[2];

  logic          gnt0, gnt1, done0, done1, done0_t, done1_t;
  logic [PW-1:0] prod0, prod0_t, prod1, prod1_t;
  logic          mul_rst, mul_start, mul_start_t;
  logic [NB-1:0] mul_multiplier, mul_multiplicand, mul_multiplier_t, mul_multiplicand_t;
  logic [PW-1:0] mul_product, mul_product_t;

  mul_share_arbiter #(.NUM_BITS(NB), .MUL_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req0(req_d[0]), .req0_t(req_t_d[0]), .a0(a_d[0]), .b0(b_d[0]), .a0_t(at_d[0]), .b0_t(bt_d[0]),
    .req1(req_d[1]), .req1_t(req_t_d[1]), .a1(a_d[1]), .b1(b_d[1]), .a1_t(at_d[1]), .b1_t(bt_d[1]),
    .gnt0(gnt0), .done0(done0), .done0_t(done0_t), .prod0(prod0), .prod0_t(prod0_t),
    .gnt1(gnt1), .done1(done1), .done1_t(done1_t), .prod1(prod1), .prod1_t(prod1_t),
    .mul_rst(mul_rst), .mul_start(mul_start), .mul_start_t(mul_start_t),
    .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
    .mul_multiplier_t(mul_multiplier_t), .mul_multiplicand_t(mul_multiplicand_t),
    .mul_product(mul_product), .mul_product_t(mul_product_t)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier stand-in: the result is valid only in the single cycle that
  // lies L cycles after mul_start drops; every other cycle shows junk.
  int            m_cnt   = 0;
  logic          m_armed = 1'b0;
  logic [PW-1:0] m_p     = '0;
  logic [PW-1:0] m_pt    = '0;
  always @(posedge clk) begin
    if (mul_rst) begin
      m_armed <= 1'b0;
    end else if (mul_start) begin
      m_armed <= 1'b1;
      m_cnt   <= L;
      m_p     <= PW'(mul_multiplier) * PW'(mul_multiplicand);
      m_pt    <= ((|mul_multiplier_t) || (|mul_multiplicand_t) || mul_start_t) ? '1 : '0;
    end else if (m_armed) begin
      if (m_cnt == 0) m_armed <= 1'b0;
      else            m_cnt   <= m_cnt - 1;
    end
  end
  assign mul_product   = (m_armed && m_cnt == 0) ? m_p  : (~m_p ^ 14'h1555);
  assign mul_product_t = (m_armed && m_cnt == 0) ? m_pt : ~m_pt;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One request on port p, from raise to done. Reports latency and observations.
  task automatic run_op(input int p, input logic [NB-1:0] a, input logic [NB-1:0] b,
                        input logic [NB-1:0] at, input logic [NB-1:0] bt, input logic rt,
                        output int lat, output logic [PW-1:0] pr, output logic [PW-1:0] prt,
                        output logic dt, output logic st_t, output logic [NB-1:0] mt);
    int g;
    int d;
    g = -1; d = -1; lat = -1; pr = '0; prt = '0; dt = 1'b0; st_t = 1'b0; mt = '0;
    a_d[p] = a; b_d[p] = b; at_d[p] = at; bt_d[p] = bt; req_t_d[p] = rt; req_d[p] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((p == 0) ? gnt0 : gnt1) begin
        g = cyc;
        break;
      end
    end
    req_d[p] = 1'b0;
    if (g < 0) begin
      check("gnt_timeout", 64'd0, 64'd1);
    end else begin
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (mul_start) begin
          st_t = mul_start_t;
          mt   = mul_multiplier_t;
        end
        if ((p == 0) ? done0 : done1) begin
          d   = cyc;
          pr  = (p == 0) ? prod0 : prod1;
          prt = (p == 0) ? prod0_t : prod1_t;
          dt  = (p == 0) ? done0_t : done1_t;
          break;
        end
      end
      if (d < 0) check("done_timeout", 64'd0, 64'd1);
      else       lat = d - g;
    end
  endtask

  typedef struct {
    int            port;
    logic [NB-1:0] a, b, at, bt;
    logic          rt;
    logic [PW-1:0] ep, ept;
  } vec_t;

  task automatic new_ops(input int p);
    int r;
    r = $urandom_range(7, 0);
    a_d[p] = (r == 0) ? 7'd0 : (r == 1) ? 7'd127 : NB'($urandom);
    r = $urandom_range(7, 0);
    b_d[p] = (r == 0) ? 7'd0 : (r == 1) ? 7'd127 : NB'($urandom);
    at_d[p]    = ($urandom_range(3, 0) == 0) ? NB'($urandom) : '0;
    bt_d[p]    = ($urandom_range(3, 0) == 0) ? NB'($urandom) : '0;
    req_t_d[p] = ($urandom_range(3, 0) == 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    vec_t          vt[6];
    logic [PW-1:0] exp_p [2];
    logic [PW-1:0] exp_pt[2];
    int            lat;
    logic [PW-1:0] pr, prt;
    logic          dt, st_t;
    logic [NB-1:0] mt;
    int            gseq[$];
    int            gcyc[$];
    int            dcyc[$];
    int            g;

    for (int p = 0; p < 2; p++) begin
      req_d[p] = 1'b0; req_t_d[p] = 1'b0; a_d[p] = '0; b_d[p] = '0; at_d[p] = '0; bt_d[p] = '0;
      exp_p[p] = '0; exp_pt[p] = '0;
    end

    // ---- reset state ----
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {gnt0, gnt1, done0, done1, done0_t, done1_t, mul_rst, mul_start, mul_start_t}, 64'd0);
    check("rst_prod", {prod0, prod0_t, prod1, prod1_t}, 64'd0);
    check("rst_mulops", {mul_multiplier, mul_multiplicand, mul_multiplier_t, mul_multiplicand_t}, 64'd0);
    rst = 1'b1;

    // ---- table of single-port operations ----
    vt[0] = '{0, 7'd15,  7'd15,  7'd0,    7'd0,    1'b0, 14'd225,   14'd0};
    vt[1] = '{1, 7'd0,   7'd0,   7'd0,    7'd0,    1'b0, 14'd0,     14'd0};
    vt[2] = '{0, 7'd127, 7'd127, 7'd0,    7'd0,    1'b0, 14'd16129, 14'd0};
    vt[3] = '{1, 7'd42,  7'd78,  7'h01,   7'd0,    1'b0, 14'd3276,  14'h3fff};
    vt[4] = '{1, 7'd5,   7'd9,   7'd0,    7'd0,    1'b1, 14'd45,    14'h3fff};
    vt[5] = '{0, 7'd1,   7'd2,   7'd0,    7'h40,   1'b0, 14'd2,     14'h3fff};
    for (int i = 0; i < 6; i++) begin
      run_op(vt[i].port, vt[i].a, vt[i].b, vt[i].at, vt[i].bt, vt[i].rt, lat, pr, prt, dt, st_t, mt);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(L + 3));
      check($sformatf("vec%0d_prod", i), pr, vt[i].ep);
      check($sformatf("vec%0d_prod_t", i), prt, vt[i].ept);
      check($sformatf("vec%0d_done_t", i), dt, vt[i].rt);
      check($sformatf("vec%0d_start_t", i), st_t, vt[i].rt);
      check($sformatf("vec%0d_mul_multiplier_t", i), mt, vt[i].at);
      exp_p[vt[i].port]  = vt[i].ep;
      exp_pt[vt[i].port] = vt[i].ept;
      check($sformatf("vec%0d_other_prod", i),
            (vt[i].port == 0) ? {prod1_t, prod1} : {prod0_t, prod0},
            {exp_pt[1 - vt[i].port], exp_p[1 - vt[i].port]});
    end

    // ---- tie after reset, then both held for 4 operations ----
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    a_d[0] = 7'd92; b_d[0] = 7'd75; a_d[1] = 7'd42; b_d[1] = 7'd78;
    for (int p = 0; p < 2; p++) begin
      at_d[p] = '0; bt_d[p] = '0; req_t_d[p] = 1'b0; req_d[p] = 1'b1;
    end
    for (int i = 0; i < 200 && dcyc.size() < 4; i++) begin
      @(negedge clk);
      if (gnt0) begin gseq.push_back(0); gcyc.push_back(cyc); end
      if (gnt1) begin gseq.push_back(1); gcyc.push_back(cyc); end
      if (gseq.size() >= 4) begin req_d[0] = 1'b0; req_d[1] = 1'b0; end
      if (done0) check("tie_prod0", prod0, 14'd6900);
      if (done1) begin
        check("tie_prod1", prod1, 14'd3276);
        check("tie_prod0_undisturbed", prod0, 14'd6900);
      end
      if (done0 || done1) dcyc.push_back(cyc);
    end
    if (gseq.size() >= 4 && dcyc.size() >= 1) begin
      for (int i = 0; i < 4; i++) check($sformatf("alt_grant%0d", i), 64'(gseq[i]), 64'(i % 2));
      check("gnt1_after_idle", 64'(gcyc[1]), 64'(dcyc[0] + 1));
    end else begin
      check("alt_grant_count", 64'(gseq.size()), 64'd4);
    end

    // ---- reset in the middle of WAIT ----
    a_d[0] = 7'd5; b_d[0] = 7'd6; req_d[0] = 1'b1;
    g = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (gnt0) begin g = cyc; break; end
    end
    req_d[0] = 1'b0;
    check("midrst_gnt_seen", 64'(g >= 0), 64'd1);
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_ctrl", {gnt0, gnt1, done0, done1, done0_t, done1_t, mul_rst, mul_start, mul_start_t}, 64'd0);
    check("midrst_prod", {prod0, prod0_t, prod1, prod1_t}, 64'd0);
    check("midrst_mulops", {mul_multiplier, mul_multiplicand, mul_multiplier_t, mul_multiplicand_t}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_done", {done0, done1}, 64'd0);
    end
    rst = 1'b1;
    run_op(0, 7'd1, 7'd2, 7'd0, 7'd0, 1'b0, lat, pr, prt, dt, st_t, mt);
    check("post_rst_latency", 64'(lat), 64'(L + 3));
    check("post_rst_prod", pr, 14'd2);

    // ---- randomized traffic against a timing/arbitration model ----
    begin
      int            free_edge, done_edge, g_edge, own, w, k;
      logic          last, op_rt, op_tnt;
      logic [NB-1:0] op_a, op_b, op_at, op_bt;
      logic [1:0]    e_gnt, e_done, e_dt;

      @(negedge clk);
      rst = 1'b0;
      for (int p = 0; p < 2; p++) begin
        req_d[p] = 1'b0; exp_p[p] = '0; exp_pt[p] = '0;
      end
      @(negedge clk);
      rst = 1'b1;
      free_edge = cyc + 1; done_edge = -1; g_edge = -1; own = 0; last = 1'b1;
      op_rt = 1'b0; op_tnt = 1'b0; op_a = '0; op_b = '0; op_at = '0; op_bt = '0;

      for (int n = 0; n < 3000; n++) begin
        @(negedge clk);
        k = cyc;
        e_gnt = '0; e_done = '0; e_dt = '0;
        // Completion: exactly L+3 edges after the grant edge.
        if (k == done_edge) begin
          e_done[own] = 1'b1;
          e_dt[own]   = op_rt;
          exp_p[own]  = PW'(op_a) * PW'(op_b);
          exp_pt[own] = op_tnt ? '1 : '0;
        end
        // Arbitration: allowed once the previous operation's done cycle is over.
        if (k >= free_edge && (req_d[0] || req_d[1])) begin
          if (req_d[0] && req_d[1]) w = (last == 1'b1) ? 0 : 1;
          else                      w = req_d[1] ? 1 : 0;
          e_gnt[w] = 1'b1;
          own = w; last = (w == 1);
          op_a = a_d[w]; op_b = b_d[w]; op_at = at_d[w]; op_bt = bt_d[w]; op_rt = req_t_d[w];
          op_tnt = (|op_at) || (|op_bt) || op_rt;
          g_edge = k; done_edge = k + L + 3; free_edge = k + L + 4;
        end
        check("rnd_gnt", {gnt1, gnt0}, e_gnt);
        check("rnd_done", {done1_t, done0_t, done1, done0}, {e_dt, e_done});
        check("rnd_prod0", {prod0_t, prod0}, {exp_pt[0], exp_p[0]});
        check("rnd_prod1", {prod1_t, prod1}, {exp_pt[1], exp_p[1]});
        if (k > g_edge && k <= done_edge)
          check("rnd_mulops", {mul_multiplicand_t, mul_multiplier_t, mul_multiplicand, mul_multiplier},
                {op_bt, op_at, op_b, op_a});
        for (int p = 0; p < 2; p++) begin
          if (e_gnt[p]) begin
            if ($urandom_range(1, 0) == 0) req_d[p] = 1'b0;
            else                           new_ops(p);
          end else if (!req_d[p] && $urandom_range(2, 0) == 0) begin
            new_ops(p);
            req_d[p] = 1'b1;
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
